// File: rtl/eab_arb_pkg.sv
// Shared types for the EAB arbiter: port ids, response tags and the EAB read latency.
package eab_arb_pkg;

    localparam int unsigned EAB_READ_LATENCY = 2;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
        logic     is_write;
    } rsp_tag_t;

endpackage

// File: rtl/eab_rsp_pipe.sv
// Fixed-depth shift register of response tags; aligns each transfer with its EAB read data.
module eab_rsp_pipe
    import eab_arb_pkg::*;
#(
    parameter int unsigned DEPTH = EAB_READ_LATENCY
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/eab_arbiter.sv
// Round-robin share of one EAB between the fetch (read-only) and data (read/write) ports;
// returns each 2-cycle-latency response to the port that issued it.
module eab_arbiter
    import eab_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rsp_valid,
    output logic [WIDTH-1:0]      if_rsp_data,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_rsp_valid,
    output logic [WIDTH-1:0]      d_rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_we,
    output logic [WIDTH-1:0]      ram_data,
    input  logic [WIDTH-1:0]      ram_q
);

    port_id_e              last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_shadow_q;
    logic [WIDTH-1:0]      data_shadow_q;
    logic                  grant_f_c;
    logic                  grant_d_c;
    rsp_tag_t              tag_in_c;
    rsp_tag_t              tag_out;

    // Grant: sole requester wins; on contention the port not granted last time wins.
    always_comb begin
        grant_f_c = 1'b0;
        grant_d_c = 1'b0;
        if (rst_n) begin
            if (if_valid && d_valid) begin
                if (last_grant_q == PORT_DATA) begin
                    grant_f_c = 1'b1;
                end else begin
                    grant_d_c = 1'b1;
                end
            end else if (if_valid) begin
                grant_f_c = 1'b1;
            end else if (d_valid) begin
                grant_d_c = 1'b1;
            end
        end
    end

    assign if_ready = grant_f_c;
    assign d_ready  = grant_d_c;

    // Idle cycles replay the last granted address/data so the EAB input stays quiet.
    always_comb begin
        ram_address = addr_shadow_q;
        ram_data    = data_shadow_q;
        ram_we      = 1'b0;
        if (grant_f_c) begin
            ram_address = if_addr;
        end else if (grant_d_c) begin
            ram_address = d_addr;
            ram_data    = d_wdata;
            ram_we      = d_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= PORT_DATA;
            addr_shadow_q <= '0;
            data_shadow_q <= '0;
        end else begin
            if (grant_f_c) begin
                last_grant_q  <= PORT_FETCH;
                addr_shadow_q <= if_addr;
            end else if (grant_d_c) begin
                last_grant_q  <= PORT_DATA;
                addr_shadow_q <= d_addr;
                data_shadow_q <= d_wdata;
            end
        end
    end

    always_comb begin
        tag_in_c          = '0;
        tag_in_c.valid    = grant_f_c | grant_d_c;
        tag_in_c.port     = grant_d_c ? PORT_DATA : PORT_FETCH;
        tag_in_c.is_write = grant_d_c & d_we;
    end

    eab_rsp_pipe #(
        .DEPTH (EAB_READ_LATENCY)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in_c),
        .tag_out (tag_out)
    );

    // Response demux: the tail tag lines up with ram_q; writes report zero data.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        if (tag_out.valid) begin
            if (tag_out.port == PORT_FETCH) begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = ram_q;
            end else begin
                d_rsp_valid = 1'b1;
                if (!tag_out.is_write) begin
                    d_rsp_data = ram_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_eab_arbiter.sv
// Directed bench for eab_arbiter with a behavioural 2-cycle EAB model.
module tb_eab_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [7:0]  if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_valid;
    logic        d_ready;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [7:0]  ram_address;
    logic        ram_we;
    logic [31:0] ram_data;
    logic [31:0] ram_q;

    int checks = 0;
    int errors = 0;

    eab_arbiter #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .ram_address  (ram_address),
        .ram_we       (ram_we),
        .ram_data     (ram_data),
        .ram_q        (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // EAB model: address/write registered on the in-clock edge, q registered one edge later.
    logic [31:0] mem [256];
    logic [7:0]  addr_q;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h30] = 32'h3030_3030;
        addr_q = 8'h0;
        ram_q  = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_address] <= ram_data;
            ram_q  <= mem[addr_q];
            addr_q <= ram_address;
        end
    end

    typedef struct {
        logic        ifv;
        logic [7:0]  ifa;
        logic        dv;
        logic        dwe;
        logic [7:0]  da;
        logic [31:0] dwd;
        logic        e_ifr;
        logic        e_dr;
        logic        e_we;
        logic [7:0]  e_addr;
        logic        e_ifrv;
        logic [31:0] e_ifrd;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    localparam int NV = 31;
    vec_t vec [NV];

    function automatic vec_t mk(input logic ifv, input logic [7:0] ifa, input logic dv,
                                input logic dwe, input logic [7:0] da, input logic [31:0] dwd,
                                input logic e_ifr, input logic e_dr, input logic e_we,
                                input logic [7:0] e_addr, input logic e_ifrv,
                                input logic [31:0] e_ifrd, input logic e_drv,
                                input logic [31:0] e_drd);
        vec_t v;
        v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_we = e_we; v.e_addr = e_addr;
        v.e_ifrv = e_ifrv; v.e_ifrd = e_ifrd; v.e_drv = e_drv; v.e_drd = e_drd;
        return v;
    endfunction

    function automatic vec_t idle(input logic [7:0] e_addr, input logic e_ifrv,
                                  input logic [31:0] e_ifrd, input logic e_drv,
                                  input logic [31:0] e_drd);
        return mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0,
                  e_addr, e_ifrv, e_ifrd, e_drv, e_drd);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ifv, input logic [7:0] ifa, input logic dv,
                         input logic dwe, input logic [7:0] da, input logic [31:0] dwd);
        if_valid = ifv; if_addr = ifa; d_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    initial begin
        // single fetch, then write-then-read to the same address
        vec[0]  = mk(1, 8'h10, 0, 0, 8'h00, 32'h0,  1, 0, 0, 8'h10, 0, 32'h0, 0, 32'h0);
        vec[1]  = idle(8'h10, 0, 32'h0, 0, 32'h0);
        vec[2]  = idle(8'h10, 1, 32'hDEAD_BEEF, 0, 32'h0);
        vec[3]  = idle(8'h10, 0, 32'h0, 0, 32'h0);
        vec[4]  = mk(0, 8'h00, 1, 1, 8'h20, 32'h1234_5678, 0, 1, 1, 8'h20, 0, 32'h0, 0, 32'h0);
        vec[5]  = mk(0, 8'h00, 1, 0, 8'h20, 32'h0, 0, 1, 0, 8'h20, 0, 32'h0, 0, 32'h0);
        vec[6]  = idle(8'h20, 0, 32'h0, 1, 32'h0);
        vec[7]  = idle(8'h20, 0, 32'h0, 1, 32'h1234_5678);
        // contention F,D,F,D; data read of 0x30 stalls one cycle then is granted
        vec[8]  = mk(1, 8'h00, 1, 0, 8'h30, 32'h0, 1, 0, 0, 8'h00, 0, 32'h0, 0, 32'h0);
        vec[9]  = mk(1, 8'h01, 1, 0, 8'h30, 32'h0, 0, 1, 0, 8'h30, 0, 32'h0, 0, 32'h0);
        vec[10] = mk(1, 8'h01, 1, 1, 8'h21, 32'hAAAA_5555, 1, 0, 0, 8'h01, 1, 32'hC0DE_0000, 0, 32'h0);
        vec[11] = mk(1, 8'h02, 1, 1, 8'h21, 32'hAAAA_5555, 0, 1, 1, 8'h21, 0, 32'h0, 1, 32'h3030_3030);
        vec[12] = mk(1, 8'h02, 0, 0, 8'h00, 32'h0, 1, 0, 0, 8'h02, 1, 32'hC0DE_0001, 0, 32'h0);
        vec[13] = idle(8'h02, 0, 32'h0, 1, 32'h0);
        vec[14] = idle(8'h02, 1, 32'hC0DE_0002, 0, 32'h0);
        vec[15] = idle(8'h02, 0, 32'h0, 0, 32'h0);
        // fetch streaming 0..7 with no bubbles
        for (int i = 0; i < 8; i++) begin
            vec[16+i] = mk(1, 8'(i), 0, 0, 8'h00, 32'h0, 1, 0, 0, 8'(i),
                           (i >= 2), (i >= 2) ? (32'hC0DE_0000 | 32'(i-2)) : 32'h0, 0, 32'h0);
        end
        vec[24] = idle(8'h07, 1, 32'hC0DE_0006, 0, 32'h0);
        vec[25] = idle(8'h07, 1, 32'hC0DE_0007, 0, 32'h0);
        vec[26] = idle(8'h07, 0, 32'h0, 0, 32'h0);
        // read back the write that waited through contention
        vec[27] = mk(0, 8'h00, 1, 0, 8'h21, 32'h0, 0, 1, 0, 8'h21, 0, 32'h0, 0, 32'h0);
        vec[28] = idle(8'h21, 0, 32'h0, 0, 32'h0);
        vec[29] = idle(8'h21, 0, 32'h0, 1, 32'hAAAA_5555);
        vec[30] = idle(8'h21, 0, 32'h0, 0, 32'h0);

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
        #3;
        chk("reset if_ready", 32'(if_ready), 32'h0);
        chk("reset d_ready", 32'(d_ready), 32'h0);
        chk("reset ram_we", 32'(ram_we), 32'h0);
        chk("reset ram_address", 32'(ram_address), 32'h0);
        chk("reset ram_data", ram_data, 32'h0);
        chk("reset if_rsp_valid", 32'(if_rsp_valid), 32'h0);
        chk("reset d_rsp_valid", 32'(d_rsp_valid), 32'h0);
        chk("reset d_rsp_data", d_rsp_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].ifv, vec[i].ifa, vec[i].dv, vec[i].dwe, vec[i].da, vec[i].dwd);
            @(negedge clk);
            chk($sformatf("row%0d if_ready", i), 32'(if_ready), 32'(vec[i].e_ifr));
            chk($sformatf("row%0d d_ready", i), 32'(d_ready), 32'(vec[i].e_dr));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(vec[i].e_we));
            chk($sformatf("row%0d ram_address", i), 32'(ram_address), 32'(vec[i].e_addr));
            if (vec[i].e_dr)
                chk($sformatf("row%0d ram_data", i), ram_data, vec[i].dwd);
            chk($sformatf("row%0d if_rsp_valid", i), 32'(if_rsp_valid), 32'(vec[i].e_ifrv));
            chk($sformatf("row%0d if_rsp_data", i), if_rsp_data, vec[i].e_ifrd);
            chk($sformatf("row%0d d_rsp_valid", i), 32'(d_rsp_valid), 32'(vec[i].e_drv));
            chk($sformatf("row%0d d_rsp_data", i), d_rsp_data, vec[i].e_drd);
            @(posedge clk);
            #1;
        end

        // reset one cycle after a fetch grant: response dropped, fetch wins next contention
        drive(1, 8'h03, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        chk("pre-reset if_ready", 32'(if_ready), 32'h1);
        @(posedge clk);
        #1;
        drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("in-reset if_rsp_valid a", 32'(if_rsp_valid), 32'h0);
        chk("in-reset ram_address", 32'(ram_address), 32'h0);
        @(posedge clk);
        #1;
        chk("in-reset if_rsp_valid b", 32'(if_rsp_valid), 32'h0);
        chk("in-reset if_rsp_data", if_rsp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 8'h04, 1, 0, 8'h05, 32'h0);
        @(negedge clk);
        chk("post-reset if_ready", 32'(if_ready), 32'h1);
        chk("post-reset d_ready", 32'(d_ready), 32'h0);
        chk("post-reset if_rsp_valid", 32'(if_rsp_valid), 32'h0);
        chk("post-reset d_rsp_valid", 32'(d_rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        drive(0, 8'h00, 1, 0, 8'h05, 32'h0);
        @(negedge clk);
        chk("post-reset d grant", 32'(d_ready), 32'h1);
        chk("post-reset no stale rsp", 32'(if_rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        chk("post-reset fetch rsp valid", 32'(if_rsp_valid), 32'h1);
        chk("post-reset fetch rsp data", if_rsp_data, 32'hC0DE_0004);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-reset data rsp valid", 32'(d_rsp_valid), 32'h1);
        chk("post-reset data rsp data", d_rsp_data, 32'hC0DE_0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
